// File: rtl/sys_bridge_pkg.sv
// Shared types and defaults for the sys_bridge_hs IO-bus to system-bus bridge.
package sys_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_e;

   localparam logic [31:0] BRIDGE_BASE_DEFAULT = 32'hC000_0000;
   localparam logic [31:0] ERR_DATA_DEFAULT    = 32'hDEAD_BEEF;

   localparam int unsigned REGION_MMIO  = 0;
   localparam int unsigned REGION_VIDEO = 1;

endpackage

// File: rtl/sys_bridge_decode.sv
// Combinational window decode: IO byte address -> hit, one-hot region select, word address.
module sys_bridge_decode
   import sys_bridge_pkg::*;
#(
   parameter logic [31:0] BRIDGE_BASE = BRIDGE_BASE_DEFAULT,
   parameter int unsigned ADDR_W      = 21,
   parameter int unsigned NUM_REGION  = 2
) (
   input  logic [31:0]           io_address,
   output logic                  hit_c,
   output logic [NUM_REGION-1:0] cs_c,
   output logic [ADDR_W-1:0]     addr_c
);

   localparam int unsigned RB = $clog2(NUM_REGION);

   logic [RB-1:0] region_idx;
   logic          unused_addr;

   assign hit_c       = (io_address[31:24] == BRIDGE_BASE[31:24]);
   assign region_idx  = io_address[23 -: RB];
   assign cs_c        = NUM_REGION'(1) << region_idx;
   assign addr_c      = io_address[ADDR_W+1:2];
   assign unused_addr = ^io_address;

endmodule

// File: rtl/sys_bridge_hs.sv
// Registered, handshaked MCS IO-bus to system-bus bridge with slave wait states.
// Define BRIDGE_TIMEOUT_EN to add a WAIT-state timeout with an error completion.
module sys_bridge_hs
   import sys_bridge_pkg::*;
#(
   parameter logic [31:0] BRIDGE_BASE = BRIDGE_BASE_DEFAULT,
   parameter int unsigned ADDR_W      = 21,
   parameter int unsigned NUM_REGION  = 2,
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter logic [31:0] ERR_DATA    = ERR_DATA_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  io_addr_strobe,
   input  logic                  io_read_strobe,
   input  logic                  io_write_strobe,
   input  logic [3:0]            io_byte_enable,
   input  logic [31:0]           io_address,
   input  logic [31:0]           io_write_data,
   output logic [31:0]           io_read_data,
   output logic                  io_ready,
   output logic [NUM_REGION-1:0] sys_cs,
   output logic                  sys_rd,
   output logic                  sys_wr,
   output logic [ADDR_W-1:0]     sys_addr,
   output logic [3:0]            sys_be,
   output logic [31:0]           sys_wr_data,
   input  logic [31:0]           sys_rd_data,
   input  logic                  sys_ack,
   output logic                  bus_err
);

   localparam int unsigned RB = $clog2(NUM_REGION);

   generate
      if ((NUM_REGION < 2) || ((NUM_REGION & (NUM_REGION - 1)) != 0)) begin : g_bad_regions
         $error("sys_bridge_hs: NUM_REGION must be a power of 2 and at least 2");
      end
      if ((ADDR_W + 2 + RB) > 24) begin : g_bad_addr_w
         $error("sys_bridge_hs: ADDR_W + 2 + clog2(NUM_REGION) must not exceed 24");
      end
   endgenerate

   logic                  dec_hit;
   logic [NUM_REGION-1:0] dec_cs;
   logic [ADDR_W-1:0]     dec_addr;

   sys_bridge_decode #(
      .BRIDGE_BASE (BRIDGE_BASE),
      .ADDR_W      (ADDR_W),
      .NUM_REGION  (NUM_REGION)
   ) u_decode (
      .io_address (io_address),
      .hit_c      (dec_hit),
      .cs_c       (dec_cs),
      .addr_c     (dec_addr)
   );

   state_e                state_q, state_d;
   logic                  write_q, write_d;
   logic                  miss_q, miss_d;
   logic                  io_ready_q, io_ready_d;
   logic [31:0]           io_read_data_q, io_read_data_d;
   logic [NUM_REGION-1:0] sys_cs_q, sys_cs_d;
   logic                  sys_rd_q, sys_rd_d;
   logic                  sys_wr_q, sys_wr_d;
   logic [ADDR_W-1:0]     sys_addr_q, sys_addr_d;
   logic [3:0]            sys_be_q, sys_be_d;
   logic [31:0]           sys_wr_data_q, sys_wr_data_d;
   logic                  start;
   logic [31:0]           ack_data;

   assign start    = io_addr_strobe & (io_read_strobe | io_write_strobe);
   assign ack_data = write_q ? 32'd0 : sys_rd_data;

`ifdef BRIDGE_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             bus_err_q, bus_err_d;
   logic             timeout;

   // cnt_q counts completed WAIT cycles; this cycle is the TIMEOUT_CYC-th one
   assign timeout = (32'(cnt_q) + 32'd1) >= 32'(TIMEOUT_CYC);
   assign bus_err = bus_err_q;
`else
   logic unused_cfg;

   assign unused_cfg = ^{ERR_DATA, 32'(TIMEOUT_CYC)};
   assign bus_err    = 1'b0;
`endif

   // Next-state and registered-output logic
   always_comb begin
      state_d        = state_q;
      write_d        = write_q;
      miss_d         = miss_q;
      io_ready_d     = 1'b0;
      io_read_data_d = io_read_data_q;
      sys_cs_d       = sys_cs_q;
      sys_rd_d       = 1'b0;
      sys_wr_d       = 1'b0;
      sys_addr_d     = sys_addr_q;
      sys_be_d       = sys_be_q;
      sys_wr_data_d  = sys_wr_data_q;
`ifdef BRIDGE_TIMEOUT_EN
      cnt_d          = cnt_q;
      bus_err_d      = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               // A miss still spends one slot in REQ so every access completes no earlier than cycle 2
               state_d = REQ;
               write_d = io_write_strobe;
               miss_d  = ~dec_hit;
               if (dec_hit) begin
                  sys_cs_d      = dec_cs;
                  sys_rd_d      = ~io_write_strobe;
                  sys_wr_d      = io_write_strobe;
                  sys_addr_d    = dec_addr;
                  sys_be_d      = io_byte_enable;
                  sys_wr_data_d = io_write_data;
               end
            end
         end

         REQ: begin
            if (miss_q) begin
               state_d        = RESP;
               io_ready_d     = 1'b1;
               io_read_data_d = 32'd0;
               sys_cs_d       = '0;
            end else if (sys_ack) begin
               state_d        = RESP;
               io_ready_d     = 1'b1;
               io_read_data_d = ack_data;
               sys_cs_d       = '0;
            end else begin
               state_d = WAIT;
`ifdef BRIDGE_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end

         WAIT: begin
            if (sys_ack) begin
               state_d        = RESP;
               io_ready_d     = 1'b1;
               io_read_data_d = ack_data;
               sys_cs_d       = '0;
            end
`ifdef BRIDGE_TIMEOUT_EN
            else if (timeout) begin
               state_d        = RESP;
               io_ready_d     = 1'b1;
               io_read_data_d = ERR_DATA;
               sys_cs_d       = '0;
               bus_err_d      = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d  = IDLE;
            sys_cs_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         write_q        <= 1'b0;
         miss_q         <= 1'b0;
         io_ready_q     <= 1'b0;
         io_read_data_q <= 32'd0;
         sys_cs_q       <= '0;
         sys_rd_q       <= 1'b0;
         sys_wr_q       <= 1'b0;
         sys_addr_q     <= '0;
         sys_be_q       <= 4'd0;
         sys_wr_data_q  <= 32'd0;
`ifdef BRIDGE_TIMEOUT_EN
         cnt_q          <= '0;
         bus_err_q      <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         write_q        <= write_d;
         miss_q         <= miss_d;
         io_ready_q     <= io_ready_d;
         io_read_data_q <= io_read_data_d;
         sys_cs_q       <= sys_cs_d;
         sys_rd_q       <= sys_rd_d;
         sys_wr_q       <= sys_wr_d;
         sys_addr_q     <= sys_addr_d;
         sys_be_q       <= sys_be_d;
         sys_wr_data_q  <= sys_wr_data_d;
`ifdef BRIDGE_TIMEOUT_EN
         cnt_q          <= cnt_d;
         bus_err_q      <= bus_err_d;
`endif
      end
   end

   assign io_ready     = io_ready_q;
   assign io_read_data = io_read_data_q;
   assign sys_cs       = sys_cs_q;
   assign sys_rd       = sys_rd_q;
   assign sys_wr       = sys_wr_q;
   assign sys_addr     = sys_addr_q;
   assign sys_be       = sys_be_q;
   assign sys_wr_data  = sys_wr_data_q;

endmodule

// File: tb/tb_sys_bridge_hs.sv
// Directed self-checking bench for sys_bridge_hs; timeout cases run when BRIDGE_TIMEOUT_EN is defined.
module tb_sys_bridge_hs;

   localparam int unsigned ADDR_W     = 21;
   localparam int unsigned NUM_REGION = 2;
`ifdef BRIDGE_TIMEOUT_EN
   localparam int unsigned TIMEOUT_CYC = 4;
`else
   localparam int unsigned TIMEOUT_CYC = 255;
`endif

   logic                  clk = 1'b0;
   logic                  reset_n;
   logic                  io_addr_strobe;
   logic                  io_read_strobe;
   logic                  io_write_strobe;
   logic [3:0]            io_byte_enable;
   logic [31:0]           io_address;
   logic [31:0]           io_write_data;
   logic [31:0]           io_read_data;
   logic                  io_ready;
   logic [NUM_REGION-1:0] sys_cs;
   logic                  sys_rd;
   logic                  sys_wr;
   logic [ADDR_W-1:0]     sys_addr;
   logic [3:0]            sys_be;
   logic [31:0]           sys_wr_data;
   logic [31:0]           sys_rd_data;
   logic                  sys_ack;
   logic                  bus_err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sys_bridge_hs #(
      .ADDR_W      (ADDR_W),
      .NUM_REGION  (NUM_REGION),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .io_addr_strobe  (io_addr_strobe),
      .io_read_strobe  (io_read_strobe),
      .io_write_strobe (io_write_strobe),
      .io_byte_enable  (io_byte_enable),
      .io_address      (io_address),
      .io_write_data   (io_write_data),
      .io_read_data    (io_read_data),
      .io_ready        (io_ready),
      .sys_cs          (sys_cs),
      .sys_rd          (sys_rd),
      .sys_wr          (sys_wr),
      .sys_addr        (sys_addr),
      .sys_be          (sys_be),
      .sys_wr_data     (sys_wr_data),
      .sys_rd_data     (sys_rd_data),
      .sys_ack         (sys_ack),
      .bus_err         (bus_err)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one strobe cycle (cycle 0); returns in cycle 1
   task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
      io_addr_strobe  = 1'b1;
      io_read_strobe  = rd;
      io_write_strobe = wr;
      io_address      = a;
      io_write_data   = d;
      io_byte_enable  = be;
      step();
      io_addr_strobe  = 1'b0;
      io_read_strobe  = 1'b0;
      io_write_strobe = 1'b0;
   endtask

   initial begin
      logic bad;
      reset_n         = 1'b0;
      io_addr_strobe  = 1'b0;
      io_read_strobe  = 1'b0;
      io_write_strobe = 1'b0;
      io_byte_enable  = 4'h0;
      io_address      = 32'h0;
      io_write_data   = 32'h0;
      sys_rd_data     = 32'h0;
      sys_ack         = 1'b0;

      step();
      step();
      check_eq("rst_io_ready", 32'(io_ready), 32'd0);
      check_eq("rst_sys_cs", 32'(sys_cs), 32'd0);
      check_eq("rst_sys_rdwr", 32'({sys_rd, sys_wr, bus_err}), 32'd0);
      check_eq("rst_io_read_data", io_read_data, 32'd0);
      reset_n = 1'b1;
      step();

      // Zero-wait write
      issue(1'b0, 1'b1, 32'hC000_0010, 32'h1234_5678, 4'hF);
      check_eq("w0_cs", 32'(sys_cs), 32'h1);
      check_eq("w0_wr", 32'(sys_wr), 32'd1);
      check_eq("w0_rd", 32'(sys_rd), 32'd0);
      check_eq("w0_addr", 32'(sys_addr), 32'd4);
      check_eq("w0_be", 32'(sys_be), 32'hF);
      check_eq("w0_wdata", sys_wr_data, 32'h1234_5678);
      check_eq("w0_ready_c1", 32'(io_ready), 32'd0);
      sys_ack = 1'b1;
      step();
      sys_ack = 1'b0;
      check_eq("w0_ready_c2", 32'(io_ready), 32'd1);
      check_eq("w0_rdata", io_read_data, 32'd0);
      check_eq("w0_cs_resp", 32'(sys_cs), 32'd0);
      check_eq("w0_wr_resp", 32'(sys_wr), 32'd0);
      step();
      check_eq("w0_ready_c3", 32'(io_ready), 32'd0);

      // Read with three wait cycles on the video region
      issue(1'b1, 1'b0, 32'hC080_0008, 32'h0, 4'hF);
      check_eq("r3_cs", 32'(sys_cs), 32'h2);
      check_eq("r3_rd", 32'(sys_rd), 32'd1);
      check_eq("r3_addr", 32'(sys_addr), 32'd2);
      step();
      check_eq("r3_rd_wait", 32'(sys_rd), 32'd0);
      check_eq("r3_cs_wait", 32'(sys_cs), 32'h2);
      check_eq("r3_addr_wait", 32'(sys_addr), 32'd2);
      step();
      check_eq("r3_ready_c3", 32'(io_ready), 32'd0);
      step();
      sys_ack     = 1'b1;
      sys_rd_data = 32'hA5A5_0001;
      step();
      sys_ack     = 1'b0;
      sys_rd_data = 32'h0;
      check_eq("r3_ready_c5", 32'(io_ready), 32'd1);
      check_eq("r3_rdata", io_read_data, 32'hA5A5_0001);
      step();
      check_eq("r3_ready_c6", 32'(io_ready), 32'd0);
      check_eq("r3_rdata_hold", io_read_data, 32'hA5A5_0001);

      // Stray ack while idle must not start anything
      sys_ack = 1'b1;
      step();
      sys_ack = 1'b0;
      check_eq("idle_ack_cs", 32'(sys_cs), 32'd0);
      check_eq("idle_ack_ready", 32'(io_ready), 32'd0);

      // Window miss
      issue(1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'hF);
      check_eq("miss_c1_cs", 32'(sys_cs), 32'd0);
      check_eq("miss_c1_rd", 32'(sys_rd), 32'd0);
      check_eq("miss_c1_ready", 32'(io_ready), 32'd0);
      step();
      check_eq("miss_c2_ready", 32'(io_ready), 32'd1);
      check_eq("miss_c2_rdata", io_read_data, 32'd0);
      check_eq("miss_c2_cs", 32'(sys_cs), 32'd0);
      step();

      // Both strobes: treated as a write, back-to-back after the miss
      issue(1'b1, 1'b1, 32'hC000_0004, 32'hCAFE_F00D, 4'h3);
      check_eq("rw_wr", 32'(sys_wr), 32'd1);
      check_eq("rw_rd", 32'(sys_rd), 32'd0);
      check_eq("rw_addr", 32'(sys_addr), 32'd1);
      check_eq("rw_be", 32'(sys_be), 32'h3);
      check_eq("rw_cs", 32'(sys_cs), 32'h1);
      sys_ack = 1'b1;
      step();
      sys_ack = 1'b0;
      check_eq("rw_ready", 32'(io_ready), 32'd1);
      step();

`ifdef BRIDGE_TIMEOUT_EN
      // Timeout: no ack through four WAIT cycles
      issue(1'b1, 1'b0, 32'hC000_0040, 32'h0, 4'hF);
      for (int i = 0; i < 4; i++) step();
      check_eq("to_ready_c5", 32'(io_ready), 32'd0);
      check_eq("to_err_c5", 32'(bus_err), 32'd0);
      step();
      check_eq("to_ready_c6", 32'(io_ready), 32'd1);
      check_eq("to_err_c6", 32'(bus_err), 32'd1);
      check_eq("to_rdata", io_read_data, 32'hDEAD_BEEF);
      check_eq("to_cs_resp", 32'(sys_cs), 32'd0);
      step();
      check_eq("to_err_c7", 32'(bus_err), 32'd0);

      // Ack on the timeout cycle wins
      issue(1'b1, 1'b0, 32'hC000_0040, 32'h0, 4'hF);
      for (int i = 0; i < 4; i++) step();
      sys_ack     = 1'b1;
      sys_rd_data = 32'h1357_9BDF;
      step();
      sys_ack     = 1'b0;
      sys_rd_data = 32'h0;
      check_eq("toack_ready", 32'(io_ready), 32'd1);
      check_eq("toack_err", 32'(bus_err), 32'd0);
      check_eq("toack_rdata", io_read_data, 32'h1357_9BDF);
      step();
`else
      // Without the timeout, WAIT holds well past 255 cycles
      issue(1'b1, 1'b0, 32'hC000_0040, 32'h0, 4'hF);
      bad = 1'b0;
      for (int i = 0; i < 300; i++) begin
         step();
         if (io_ready !== 1'b0 || bus_err !== 1'b0) bad = 1'b1;
      end
      check_eq("longwait_quiet", 32'(bad), 32'd0);
      check_eq("longwait_cs", 32'(sys_cs), 32'h1);
      sys_ack     = 1'b1;
      sys_rd_data = 32'h0F0F_0F0F;
      step();
      sys_ack     = 1'b0;
      sys_rd_data = 32'h0;
      check_eq("longwait_ready", 32'(io_ready), 32'd1);
      check_eq("longwait_rdata", io_read_data, 32'h0F0F_0F0F);
      step();
`endif

      // Asynchronous reset during WAIT
      issue(1'b1, 1'b0, 32'hC000_0020, 32'h0, 4'hF);
      step();
      check_eq("rw_wait_cs", 32'(sys_cs), 32'h1);
      reset_n = 1'b0;
      #1;
      check_eq("arst_cs", 32'(sys_cs), 32'd0);
      check_eq("arst_addr", 32'(sys_addr), 32'd0);
      check_eq("arst_rdata", io_read_data, 32'd0);
      check_eq("arst_ready", 32'(io_ready), 32'd0);
      step();
      step();
      check_eq("arst_no_ready", 32'(io_ready), 32'd0);
      reset_n = 1'b1;
      step();
      issue(1'b1, 1'b0, 32'hC080_0004, 32'h0, 4'hF);
      check_eq("post_cs", 32'(sys_cs), 32'h2);
      check_eq("post_addr", 32'(sys_addr), 32'd1);
      sys_ack     = 1'b1;
      sys_rd_data = 32'h2468_ACE0;
      step();
      sys_ack     = 1'b0;
      sys_rd_data = 32'h0;
      check_eq("post_ready", 32'(io_ready), 32'd1);
      check_eq("post_rdata", io_read_data, 32'h2468_ACE0);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
